// File: rtl/nios_system_pio_sense_in.sv
// nios_system_pio_sense_in: debounced input PIO with rising-edge capture and maskable level irq.
module nios_system_pio_sense_in #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    logic [WIDTH-1:0] sync1, sync2, db, db_nxt, irq_mask, edge_cap, clr;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic wr, unused_ok;
    assign wr = chipselect & ~write_n;
    assign unused_ok = ^writedata;
    // a mismatch run restarts from zero whenever sync2 falls back to db
    always_comb begin
        db_nxt = db;
        cnt_nxt = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == db[i]) cnt_nxt[i] = '0;
            else if (cnt[i] == CNT_LAST) begin
                db_nxt[i] = sync2[i];
                cnt_nxt[i] = '0;
            end else cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
    end
    assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db <= '0;
            cnt <= '{default: '0};
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            db <= db_nxt;
            cnt <= cnt_nxt;
            edge_cap <= (edge_cap & ~clr) | (db_nxt & ~db);
            if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
        end
    end
    always_comb
        readdata = !chipselect       ? '0 :
                   address == 2'd0   ? 32'(db) :
                   address == 2'd2   ? 32'(irq_mask) :
                   address == 2'd3   ? 32'(edge_cap) : '0;
    assign irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_nios_system_pio_sense_in.sv
// tb_nios_system_pio_sense_in: scoreboard bench with directed scenarios and a randomized phase.
module tb_nios_system_pio_sense_in;
    localparam int W = 8;
    localparam int D = 4;
    logic clk, reset_n, chipselect, write_n, irq, chk;
    logic [1:0] address;
    logic [31:0] writedata, readdata;
    logic [W-1:0] in_port;
    int total = 0, bad = 0;

    nios_system_pio_sense_in #(.WIDTH(W), .DEBOUNCE(D)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] d; logic i;} exp_t;
    exp_t q[$];

    // reference: db takes a new level once the D most recent synchronized samples all disagree with it
    logic [W-1:0] m_db = '0, m_mask = '0, m_cap = '0;
    logic [W-1:0] smp[$];

    function automatic logic [31:0] m_read(input logic cs, input logic [1:0] a);
        if (!cs) return 32'h0;
        case (a)
            2'd0: return 32'(m_db);
            2'd2: return 32'(m_mask);
            2'd3: return 32'(m_cap);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [W-1:0] nd, clr;
        bit st;
        if (!reset_n) begin
            m_db = '0; m_mask = '0; m_cap = '0;
            smp.delete();
            repeat (D + 1) smp.push_back('0);
        end else begin
            nd = m_db;
            for (int i = 0; i < W; i++) begin
                st = 1;
                for (int j = 1; j <= D; j++)
                    if (smp[smp.size() - 1 - j][i] == m_db[i]) st = 0;
                if (st) nd[i] = ~m_db[i];
            end
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            m_cap = (m_cap & ~clr) | (nd & ~m_db);
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_db = nd;
            smp.push_back(in_port);
            if (smp.size() > D + 1) void'(smp.pop_front());
        end
    endtask

    task automatic cyc(input logic rn, input logic cs, input logic we, input logic [1:0] a,
                       input logic [31:0] wd, input logic ck, input logic kexp,
                       input logic [31:0] kd, input logic ki);
        exp_t e;
        reset_n = rn; chipselect = cs; write_n = ~we; address = a; writedata = wd; chk = ck;
        if (ck) begin
            e.d = kexp ? kd : m_read(cs, a);
            e.i = kexp ? ki : |(m_cap & m_mask);
            q.push_back(e);
        end
        @(posedge clk);
        model_step();
        #1;
        chk = 0;
    endtask

    task automatic rdk(input logic [1:0] a, input logic [31:0] v, input logic ir);
        cyc(1, 1, 0, a, 0, 1, 1, v, ir);
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1, 1, 1, a, d, 0, 0, 0, 0);
    endtask
    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk) begin
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: read presented with no expectation queued");
            end else begin
                exp_t e;
                e = q.pop_front();
                total += 2;
                if (readdata !== e.d) begin
                    bad++;
                    $display("FAIL readdata addr=%0d cs=%0b: got %h want %h at %0t", address, chipselect, readdata, e.d, $time);
                end
                if (irq !== e.i) begin
                    bad++;
                    $display("FAIL irq: got %b want %b at %0t", irq, e.i, $time);
                end
            end
        end
    end

    initial begin
        int hold;
        logic [31:0] r;
        reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; in_port = 0; chk = 0;
        repeat (D + 1) smp.push_back('0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) cyc(0, 1, 0, 2'(a), 0, 1, 1, 0, 0);
        // level 05 held from the last reset edge: visible after the sixth edge
        in_port = 8'h05;
        for (int e = 0; e <= 6; e++) rdk(0, (e < 6) ? 32'h0 : 32'h5, 0);
        rdk(3, 32'h5, 0);
        // glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
        in_port = 0; idle(8); wr(3, 32'hFF);
        in_port = 8'h01; idle(3); in_port = 0; idle(8);
        rdk(0, 0, 0); rdk(3, 0, 0);
        in_port = 8'h01; idle(4); in_port = 0; idle(2);
        rdk(0, 1, 0); rdk(3, 1, 0); idle(8);
        // irq masking and write-1-to-clear
        wr(2, 1); rdk(2, 1, 1); wr(3, 1); rdk(3, 0, 0);
        in_port = 8'h01; idle(4); in_port = 0; idle(8);
        rdk(3, 1, 1); wr(2, 0); rdk(3, 1, 0);
        // set wins over a coincident clear
        wr(3, 32'hFF); in_port = 8'h02; idle(5); wr(3, 32'h2);
        rdk(3, 2, 0); rdk(0, 2, 0);
        // writes to read-only/reserved addresses; mask width truncation
        wr(0, 32'hFFFF_FFFF); wr(1, 32'hFFFF_FFFF);
        rdk(0, 2, 0); rdk(1, 0, 0); rdk(3, 2, 0);
        wr(2, 32'hFFFF_FF0F); rdk(2, 32'h0F, 1);
        // reset mid-debounce with irq pending, then re-acceptance of held input
        in_port = 8'h03; idle(3); rdk(2, 32'h0F, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int e = 0; e <= 6; e++) rdk((e < 4) ? 2'(e) : 2'd0, (e == 6) ? 32'h3 : 32'h0, 0);
        rdk(3, 32'h3, 0);
        // randomized traffic against the reference model
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                in_port = ($urandom_range(0, 2) == 0) ? in_port ^ W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            r = $urandom;
            case ($urandom_range(0, 9))
                0: cyc(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
                1, 2: wr(2'($urandom_range(0, 3)), r);
                3: cyc(1, 0, 0, 2'($urandom_range(0, 3)), 0, 1, 0, 0, 0);
                default: cyc(1, 1, 0, 2'($urandom_range(0, 3)), 0, 1, 0, 0, 0);
            endcase
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
